operand_hazard_ctrl: RTL and testbench
======================================

# operand_hazard_ctrl

Stall controller for the stall-only ("suspend") pipeline. It sits on the producer side of the register operands that the ALU operand mux consumes. It tracks destination registers still in flight in EX, MEM and WB, and compares them against the source registers that the instruction in ID actually uses. On a match it freezes PC and IF/ID and inserts a bubble into ID/EX until the producer has written the register file. It also keeps a saturating count of stall cycles for on-board performance readout.

## Interface
- WB_BYPASS, 1'b1: 1 = register file is write-first (a WB-stage write is visible to an ID read in the same cycle); 0 = the WB stage also causes a hazard.
- CNT_W, 32: width of the stall-cycle counter.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_n_i  in  1  reset, synchronous, active-low.
- id_valid_i  in  1  ID holds a real instruction.
- id_rs1_i  in  5  source register 1 of the ID instruction.
- id_rs2_i  in  5  source register 2 of the ID instruction.
- id_rs1_used_i  in  1  the instruction reads rs1 (operand A selects rD1).
- id_rs2_used_i  in  1  the instruction reads rs2 (operand B selects rD2, or store/branch compare).
- id_rd_i  in  5  destination register of the ID instruction.
- id_we_i  in  1  the ID instruction writes rd.
- flush_i  in  1  taken branch/jump resolved in EX; kills the IF and ID instructions this cycle.
- stall_pc_o  out  1  hold PC.
- stall_ifid_o  out  1  hold the IF/ID register.
- bubble_idex_o  out  1  load a NOP into ID/EX.
- hazard_o  out  1  raw hazard detect (debug).
- stall_cnt_o  out  CNT_W  saturating count of stall cycles.

## Operation
- Scoreboard: three entries (EX, MEM, WB), each holding {v, rd}. An entry with v=1 means a pending write to rd. rd=0 is never stored with v=1.
- Match rule: match(r) = (r != 0) AND one of the following holds: EX.v & EX.rd==r; MEM.v & MEM.rd==r; or (!WB_BYPASS & WB.v & WB.rd==r).
- hazard_o = id_valid_i & ~flush_i & ((id_rs1_used_i & match(id_rs1_i)) | (id_rs2_used_i & match(id_rs2_i))).
- Outputs:
  - stall_pc_o = stall_ifid_o = hazard_o.
  - bubble_idex_o = hazard_o | flush_i.
- Shift each cycle:
  - WB <= MEM.
  - MEM <= EX.
  - EX <= {id_valid_i & id_we_i & (id_rd_i!=0) & ~hazard_o & ~flush_i, id_rd_i}.
- A bubble always enters EX with v=0, whether caused by a stall or a flush.
- Flush priority: flush_i masks hazard_o, so the killed ID instruction never stalls. Older entries (EX/MEM/WB) are never cleared by flush.
- Unused source fields are ignored even if they match (e.g. the imm form with rs2 bits equal to a pending rd).
- stall_cnt_o increments by 1 in each cycle where hazard_o=1. It saturates at all-ones and never wraps.

## Timing
- Detection and all control outputs are combinational from the current scoreboard and the ID inputs. There is no added latency.
- Stall length after a dependent producer, in cycles:
  - WB_BYPASS=1: 2 if the producer is in EX, 1 if in MEM, 0 if in WB.
  - WB_BYPASS=0: 3 if the producer is in EX, 2 if in MEM, 1 if in WB.
- Stall never exceeds 3 cycles. The scoreboard drains because bubbles enter EX.
- During a stall the ID inputs are held stable by IF/ID. The block needs no internal copy of them.
- Reset:
  - When rst_n_i=0 at a rising edge, all entries go to v=0 and rd=0, and stall_cnt_o goes to 0.
  - Hence in the cycle after reset, hazard_o, stall_pc_o, stall_ifid_o and bubble_idex_o are all 0, unless flush_i is asserted.
  - Reset asserted mid-stall drops the stall on the next cycle. Pending writes are forgotten; the pipeline is reset together with this block.
- Simultaneous events:
  - flush_i together with a hazard: the outputs are bubble=1 and stall=0, and the counter does not increment.
  - rs1==rs2 with both used counts as one hazard and one count per cycle.

## Test plan
- Back-to-back RAW, WB_BYPASS=1: addi x5,x0,1 then add x6,x5,x5.
  - Required: stall_pc_o=1 for exactly 2 cycles, bubble_idex_o=1 for 2 cycles.
  - The consumer enters EX on cycle 3; stall_cnt_o=2.
- Same sequence with WB_BYPASS=0: 3 stall cycles; stall_cnt_o=3.
- x0 and unused operands:
  - Producer writing x0 followed by an add reading x0: no stall.
  - addi x7 followed by addi x8,x9,imm where the rs2 field equals 7 and rs2_used=0: no stall.
- Distance-2 dependency: producer, independent instruction, consumer. Required: exactly 1 stall cycle with WB_BYPASS=1, 2 with WB_BYPASS=0.
- Flush during stall: flush_i=1 in the first stall cycle.
  - Required: stall_pc_o=0, bubble_idex_o=1 that cycle, and the EX entry v=0 next cycle.
  - stall_cnt_o is unchanged.
- Reset and saturation:
  - Pull rst_n_i low during a stall. Next cycle all outputs are 0 and stall_cnt_o=0.
  - With CNT_W=4, force 20 stall cycles. stall_cnt_o holds at 15.

Source files
------------

// File: rtl/operand_hazard_ctrl.sv
// operand_hazard_ctrl: RAW stall controller tracking EX/MEM/WB destination registers against ID sources; holds PC and IF/ID, bubbles ID/EX, and counts stall cycles with saturation
module operand_hazard_ctrl #(
  parameter bit WB_BYPASS = 1'b1,
  parameter int CNT_W     = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             id_valid_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_rs1_used_i,
  input  logic             id_rs2_used_i,
  input  logic [4:0]       id_rd_i,
  input  logic             id_we_i,
  input  logic             flush_i,
  output logic             stall_pc_o,
  output logic             stall_ifid_o,
  output logic             bubble_idex_o,
  output logic             hazard_o,
  output logic [CNT_W-1:0] stall_cnt_o
);
  logic             r_ex_v, r_mem_v, r_wb_v;
  logic [4:0]       r_ex_rd, r_mem_rd, r_wb_rd;
  logic [CNT_W-1:0] r_cnt;
  logic             w_m1, w_m2, w_haz;
  assign w_m1 = (id_rs1_i != 5'd0) & ((r_ex_v & (r_ex_rd == id_rs1_i)) |
                (r_mem_v & (r_mem_rd == id_rs1_i)) |
                (!WB_BYPASS & r_wb_v & (r_wb_rd == id_rs1_i)));
  assign w_m2 = (id_rs2_i != 5'd0) & ((r_ex_v & (r_ex_rd == id_rs2_i)) |
                (r_mem_v & (r_mem_rd == id_rs2_i)) |
                (!WB_BYPASS & r_wb_v & (r_wb_rd == id_rs2_i)));
  assign w_haz         = id_valid_i & ~flush_i & ((id_rs1_used_i & w_m1) | (id_rs2_used_i & w_m2));
  assign hazard_o      = w_haz;
  assign stall_pc_o    = w_haz;
  assign stall_ifid_o  = w_haz;
  assign bubble_idex_o = w_haz | flush_i;
  assign stall_cnt_o   = r_cnt;
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_ex_v   <= 1'b0;
      r_mem_v  <= 1'b0;
      r_wb_v   <= 1'b0;
      r_ex_rd  <= 5'd0;
      r_mem_rd <= 5'd0;
      r_wb_rd  <= 5'd0;
      r_cnt    <= '0;
    end else begin
      r_wb_v   <= r_mem_v;
      r_wb_rd  <= r_mem_rd;
      r_mem_v  <= r_ex_v;
      r_mem_rd <= r_ex_rd;
      r_ex_v   <= id_valid_i & id_we_i & (id_rd_i != 5'd0) & ~w_haz & ~flush_i;
      r_ex_rd  <= id_rd_i;
      r_cnt    <= r_cnt + {{(CNT_W-1){1'b0}}, w_haz & ~&r_cnt};
    end
  end
endmodule

// File: tb/tb_operand_hazard_ctrl.sv
// tb_operand_hazard_ctrl: directed checks of stall length, x0/unused operands, flush, reset and counter saturation
module tb_operand_hazard_ctrl;
  typedef struct packed {
    logic       v;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       we;
    logic       fl;
  } id_t;
  localparam id_t IDLE = '{v:1'b0, rs1:5'd0, rs2:5'd0, u1:1'b0, u2:1'b0, rd:5'd0, we:1'b0, fl:1'b0};
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  id_t         idr [3];
  logic        spc [3];
  logic        sif [3];
  logic        bub [3];
  logic        haz [3];
  logic [31:0] cnt0, cnt1;
  logic [3:0]  cnt2;
  int          n_chk = 0;
  int          n_fail = 0;
  always #5 clk = ~clk;
  operand_hazard_ctrl #(.WB_BYPASS(1'b1), .CNT_W(32)) u_b1 (
    .clk_i(clk), .rst_n_i(rst_n), .id_valid_i(idr[0].v), .id_rs1_i(idr[0].rs1), .id_rs2_i(idr[0].rs2),
    .id_rs1_used_i(idr[0].u1), .id_rs2_used_i(idr[0].u2), .id_rd_i(idr[0].rd), .id_we_i(idr[0].we),
    .flush_i(idr[0].fl), .stall_pc_o(spc[0]), .stall_ifid_o(sif[0]), .bubble_idex_o(bub[0]),
    .hazard_o(haz[0]), .stall_cnt_o(cnt0));
  operand_hazard_ctrl #(.WB_BYPASS(1'b0), .CNT_W(32)) u_b0 (
    .clk_i(clk), .rst_n_i(rst_n), .id_valid_i(idr[1].v), .id_rs1_i(idr[1].rs1), .id_rs2_i(idr[1].rs2),
    .id_rs1_used_i(idr[1].u1), .id_rs2_used_i(idr[1].u2), .id_rd_i(idr[1].rd), .id_we_i(idr[1].we),
    .flush_i(idr[1].fl), .stall_pc_o(spc[1]), .stall_ifid_o(sif[1]), .bubble_idex_o(bub[1]),
    .hazard_o(haz[1]), .stall_cnt_o(cnt1));
  operand_hazard_ctrl #(.WB_BYPASS(1'b1), .CNT_W(4)) u_sat (
    .clk_i(clk), .rst_n_i(rst_n), .id_valid_i(idr[2].v), .id_rs1_i(idr[2].rs1), .id_rs2_i(idr[2].rs2),
    .id_rs1_used_i(idr[2].u1), .id_rs2_used_i(idr[2].u2), .id_rd_i(idr[2].rd), .id_we_i(idr[2].we),
    .flush_i(idr[2].fl), .stall_pc_o(spc[2]), .stall_ifid_o(sif[2]), .bubble_idex_o(bub[2]),
    .hazard_o(haz[2]), .stall_cnt_o(cnt2));
  function automatic logic [31:0] gc(input int k);
    return k == 0 ? cnt0 : k == 1 ? cnt1 : {28'd0, cnt2};
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic nxt;
    @(negedge clk);
  endtask
  task automatic producer(input int k, input logic [4:0] rd);
    idr[k] = '{v:1'b1, rs1:5'd0, rs2:5'd0, u1:1'b1, u2:1'b0, rd:rd, we:1'b1, fl:1'b0};
  endtask
  task automatic drain(input int k);
    idr[k] = IDLE;
    repeat (4) nxt;
  endtask
  task automatic seq(input int k, input logic [4:0] prd, input int gap, input logic [4:0] r1,
                     input logic [4:0] r2, input logic u1, input logic u2, input int exp);
    int n = 0;
    producer(k, prd);
    nxt;
    repeat (gap) begin
      idr[k] = '{v:1'b1, rs1:5'd0, rs2:5'd0, u1:1'b0, u2:1'b0, rd:5'd10, we:1'b1, fl:1'b0};
      nxt;
    end
    idr[k] = '{v:1'b1, rs1:r1, rs2:r2, u1:u1, u2:u2, rd:5'd6, we:1'b1, fl:1'b0};
    #1;
    while (haz[k] && n < 8) begin
      chk("stall_pc", spc[k], 1);
      chk("stall_ifid", sif[k], 1);
      chk("bubble", bub[k], 1);
      n++;
      nxt;
      #1;
    end
    chk("stall_len", n, exp);
    chk("bubble_released", bub[k], 0);
    drain(k);
  endtask
  initial begin
    logic [31:0] c;
    for (int i = 0; i < 3; i++) idr[i] = IDLE;
    nxt;
    nxt;
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_haz", haz[i], 0);
      chk("rst_spc", spc[i], 0);
      chk("rst_bub", bub[i], 0);
      chk("rst_cnt", gc(i), 0);
    end
    nxt;
    c = gc(0);
    seq(0, 5'd5, 0, 5'd5, 5'd5, 1, 1, 2);
    chk("cnt_b2b_byp1", gc(0), c + 2);
    c = gc(1);
    seq(1, 5'd5, 0, 5'd5, 5'd5, 1, 1, 3);
    chk("cnt_b2b_byp0", gc(1), c + 3);
    seq(0, 5'd5, 1, 5'd5, 5'd0, 1, 0, 1);
    seq(1, 5'd5, 1, 5'd0, 5'd5, 0, 1, 2);
    seq(0, 5'd5, 2, 5'd5, 5'd5, 1, 1, 0);
    seq(1, 5'd5, 2, 5'd5, 5'd5, 1, 1, 1);
    c = gc(0);
    seq(0, 5'd0, 0, 5'd0, 5'd0, 1, 1, 0);
    seq(0, 5'd7, 0, 5'd9, 5'd7, 1, 0, 0);
    seq(1, 5'd7, 0, 5'd9, 5'd7, 1, 0, 0);
    chk("cnt_no_stall", gc(0), c);
    producer(0, 5'd5);
    nxt;
    idr[0] = '{v:1'b1, rs1:5'd5, rs2:5'd5, u1:1'b1, u2:1'b1, rd:5'd6, we:1'b1, fl:1'b1};
    #1;
    c = gc(0);
    chk("flush_haz", haz[0], 0);
    chk("flush_spc", spc[0], 0);
    chk("flush_sif", sif[0], 0);
    chk("flush_bub", bub[0], 1);
    nxt;
    idr[0] = '{v:1'b1, rs1:5'd6, rs2:5'd0, u1:1'b1, u2:1'b0, rd:5'd11, we:1'b0, fl:1'b0};
    #1;
    chk("flush_ex_empty", haz[0], 0);
    chk("flush_cnt", gc(0), c);
    idr[0].rs1 = 5'd5;
    #1;
    chk("flush_keeps_mem", haz[0], 1);
    drain(0);
    producer(0, 5'd5);
    nxt;
    idr[0] = '{v:1'b1, rs1:5'd5, rs2:5'd0, u1:1'b1, u2:1'b0, rd:5'd6, we:1'b1, fl:1'b0};
    #1;
    chk("pre_rst_haz", haz[0], 1);
    rst_n = 1'b0;
    nxt;
    rst_n = 1'b1;
    #1;
    chk("mid_rst_haz", haz[0], 0);
    chk("mid_rst_spc", spc[0], 0);
    chk("mid_rst_sif", sif[0], 0);
    chk("mid_rst_bub", bub[0], 0);
    chk("mid_rst_cnt", gc(0), 0);
    chk("mid_rst_cnt_sat", gc(2), 0);
    drain(0);
    for (int i = 0; i < 10; i++) begin
      seq(2, 5'd5, 0, 5'd5, 5'd5, 1, 1, 2);
      if (i == 6) chk("sat_cnt_14", gc(2), 14);
    end
    chk("sat_cnt_15", gc(2), 15);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
